// File: rtl/axi4_lite_pkg.sv
// rtl/axi4_lite_pkg.sv - AXI4-Lite response/protection codes and master FSM state encoding
//
// Shared between the AXI4-Lite master and slave sides of the control path.
// Holds the response codes, the default protection value and the master FSM
// state encoding.

package axi4_lite_pkg;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // Unprivileged, secure, data access.
    localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

    localparam int         STATE_WIDTH = 3;
    localparam logic [2:0] IDLE        = 3'd0;
    localparam logic [2:0] WR_REQ      = 3'd1;
    localparam logic [2:0] WR_RESP     = 3'd2;
    localparam logic [2:0] RD_REQ      = 3'd3;
    localparam logic [2:0] RD_DATA     = 3'd4;
    localparam logic [2:0] RSP         = 3'd5;

endpackage

// File: rtl/axi4_lite_master.sv
// rtl/axi4_lite_master.sv - single-outstanding AXI4-Lite initiator driven by a local command/response port
//
// Accepts one read or write command on the cmd_* port, performs exactly one
// AXI4-Lite transaction and returns the result on the rsp_* port.
// Ports:
//   m_axi_ctrl_aclk / m_axi_ctrl_areset : clock, synchronous active-high reset
//   cmd_valid/ready, cmd_write, cmd_addr, cmd_wdata, cmd_wstrb : command in
//   rsp_valid/ready, rsp_write, rsp_rdata, rsp_resp            : response out
//   m_axi_ctrl_aw*, w*, b*, ar*, r*                           : AXI4-Lite master

module axi4_lite_master
    import axi4_lite_pkg::*;
#(
    parameter  int ADDRESS_WIDTH = 32,
    parameter  int DATA_WIDTH    = 32,
    localparam int STRB_WIDTH    = DATA_WIDTH / 8
) (
    input  logic                     m_axi_ctrl_aclk,
    input  logic                     m_axi_ctrl_areset,

    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic                     cmd_write,
    input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
    input  logic [DATA_WIDTH-1:0]    cmd_wdata,
    input  logic [STRB_WIDTH-1:0]    cmd_wstrb,

    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic                     rsp_write,
    output logic [DATA_WIDTH-1:0]    rsp_rdata,
    output logic [1:0]               rsp_resp,

    output logic [ADDRESS_WIDTH-1:0] m_axi_ctrl_awaddr,
    output logic                     m_axi_ctrl_awvalid,
    input  logic                     m_axi_ctrl_awready,
    output logic [2:0]               m_axi_ctrl_awprot,

    output logic [DATA_WIDTH-1:0]    m_axi_ctrl_wdata,
    output logic [STRB_WIDTH-1:0]    m_axi_ctrl_wstrb,
    output logic                     m_axi_ctrl_wvalid,
    input  logic                     m_axi_ctrl_wready,

    input  logic [1:0]               m_axi_ctrl_bresp,
    input  logic                     m_axi_ctrl_bvalid,
    output logic                     m_axi_ctrl_bready,

    output logic [ADDRESS_WIDTH-1:0] m_axi_ctrl_araddr,
    output logic                     m_axi_ctrl_arvalid,
    input  logic                     m_axi_ctrl_arready,
    output logic [2:0]               m_axi_ctrl_arprot,

    input  logic [DATA_WIDTH-1:0]    m_axi_ctrl_rdata,
    input  logic [1:0]               m_axi_ctrl_rresp,
    input  logic                     m_axi_ctrl_rvalid,
    output logic                     m_axi_ctrl_rready
);

    logic [STATE_WIDTH-1:0]   state;
    logic [ADDRESS_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0]    wdata_q;
    logic [STRB_WIDTH-1:0]    wstrb_q;
    logic                     awvalid_q;
    logic                     wvalid_q;
    logic                     arvalid_q;
    logic                     aw_done;
    logic                     w_done;

    // A write channel is finished once its valid has dropped or is being
    // accepted this cycle; AW and W complete independently in any order.
    assign aw_done = !awvalid_q || m_axi_ctrl_awready;
    assign w_done  = !wvalid_q  || m_axi_ctrl_wready;

    assign cmd_ready = (state == IDLE) && !m_axi_ctrl_areset;
    assign rsp_valid = (state == RSP);

    assign m_axi_ctrl_awaddr  = addr_q;
    assign m_axi_ctrl_awvalid = awvalid_q;
    assign m_axi_ctrl_awprot  = AXI_PROT_DEFAULT;
    assign m_axi_ctrl_wdata   = wdata_q;
    assign m_axi_ctrl_wstrb   = wstrb_q;
    assign m_axi_ctrl_wvalid  = wvalid_q;
    assign m_axi_ctrl_bready  = (state == WR_RESP);
    assign m_axi_ctrl_araddr  = addr_q;
    assign m_axi_ctrl_arvalid = arvalid_q;
    assign m_axi_ctrl_arprot  = AXI_PROT_DEFAULT;
    assign m_axi_ctrl_rready  = (state == RD_DATA);

    // Command payload: only loaded on accept, so it stays stable while the
    // corresponding AXI valids are pending. No reset needed on datapath.
    always_ff @(posedge m_axi_ctrl_aclk) begin
        if (state == IDLE && cmd_valid) begin
            addr_q  <= cmd_addr;
            wdata_q <= cmd_wdata;
            wstrb_q <= cmd_wstrb;
        end
    end

    always_ff @(posedge m_axi_ctrl_aclk) begin
        if (m_axi_ctrl_areset) begin
            state     <= IDLE;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rsp_write <= 1'b0;
            rsp_rdata <= '0;
            rsp_resp  <= AXI_RESP_OKAY;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        rsp_write <= cmd_write;
                        if (cmd_write) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= WR_REQ;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= RD_REQ;
                        end
                    end
                end
                WR_REQ: begin
                    if (m_axi_ctrl_awready) awvalid_q <= 1'b0;
                    if (m_axi_ctrl_wready)  wvalid_q  <= 1'b0;
                    if (aw_done && w_done)  state     <= WR_RESP;
                end
                WR_RESP: begin
                    if (m_axi_ctrl_bvalid) begin
                        rsp_resp  <= m_axi_ctrl_bresp;
                        rsp_rdata <= '0;
                        state     <= RSP;
                    end
                end
                RD_REQ: begin
                    if (m_axi_ctrl_arready) begin
                        arvalid_q <= 1'b0;
                        state     <= RD_DATA;
                    end
                end
                RD_DATA: begin
                    if (m_axi_ctrl_rvalid) begin
                        rsp_resp  <= m_axi_ctrl_rresp;
                        rsp_rdata <= m_axi_ctrl_rdata;
                        state     <= RSP;
                    end
                end
                RSP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_lite_master.sv
// tb/tb_axi4_lite_master.sv - directed and random self-checking bench for axi4_lite_master

module tb_axi4_lite_master;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_q = 1'b1;
    int          cyc = 0;

    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_wstrb = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [2:0]  awprot;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [2:0]  arprot;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    int n_cmp = 0;
    int n_fail = 0;

    axi4_lite_master dut (
        .m_axi_ctrl_aclk    (clk),
        .m_axi_ctrl_areset  (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_write          (cmd_write),
        .cmd_addr           (cmd_addr),
        .cmd_wdata          (cmd_wdata),
        .cmd_wstrb          (cmd_wstrb),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .rsp_write          (rsp_write),
        .rsp_rdata          (rsp_rdata),
        .rsp_resp           (rsp_resp),
        .m_axi_ctrl_awaddr  (awaddr),
        .m_axi_ctrl_awvalid (awvalid),
        .m_axi_ctrl_awready (awready),
        .m_axi_ctrl_awprot  (awprot),
        .m_axi_ctrl_wdata   (wdata),
        .m_axi_ctrl_wstrb   (wstrb),
        .m_axi_ctrl_wvalid  (wvalid),
        .m_axi_ctrl_wready  (wready),
        .m_axi_ctrl_bresp   (bresp),
        .m_axi_ctrl_bvalid  (bvalid),
        .m_axi_ctrl_bready  (bready),
        .m_axi_ctrl_araddr  (araddr),
        .m_axi_ctrl_arvalid (arvalid),
        .m_axi_ctrl_arready (arready),
        .m_axi_ctrl_arprot  (arprot),
        .m_axi_ctrl_rdata   (rdata),
        .m_axi_ctrl_rresp   (rresp),
        .m_axi_ctrl_rvalid  (rvalid),
        .m_axi_ctrl_rready  (rready)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    // ---------------- slave model (16-word memory at 0x00..0x3C) ----------------
    logic [31:0] mem [16];
    logic [31:0] ref_mem [16];
    int aw_lat = 0, w_lat = 0, b_lat = 0, ar_lat = 0, r_lat = 0;
    int aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    bit aw_got = 0, w_got = 0, ar_got = 0, b_fire = 0, r_fire = 0;
    int n_aw = 0, n_w = 0, n_b = 0, n_ar = 0, n_r = 0;
    logic [31:0] s_awaddr = '0, s_wdata = '0, s_araddr = '0;
    logic [3:0]  s_wstrb = '0;

    initial begin
        awready = 0; wready = 0; bvalid = 0; bresp = 0;
        arready = 0; rvalid = 0; rdata = 0; rresp = 0;
        forever begin
            @(negedge clk);
            awready = 0; wready = 0; arready = 0;
            if (rst_q) begin
                bvalid = 0; rvalid = 0;
                aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
            end else begin
                if (b_fire) begin
                    bvalid = 0; b_fire = 0; aw_got = 0; w_got = 0;
                    aw_cnt = 0; w_cnt = 0; b_cnt = 0;
                end
                if (r_fire) begin
                    rvalid = 0; r_fire = 0; ar_got = 0; ar_cnt = 0; r_cnt = 0;
                end
                if (aw_got && w_got && !bvalid) begin
                    if (b_cnt >= b_lat) begin
                        bvalid = 1;
                        bresp  = (s_awaddr < 64) ? 2'b00 : 2'b11;
                        if (s_awaddr < 64)
                            for (int i = 0; i < 4; i++)
                                if (s_wstrb[i]) mem[s_awaddr[5:2]][8*i +: 8] = s_wdata[8*i +: 8];
                    end else b_cnt++;
                end
                if (bvalid && bready) begin b_fire = 1; n_b++; end
                if (ar_got && !rvalid) begin
                    if (r_cnt >= r_lat) begin
                        rvalid = 1;
                        rdata  = (s_araddr < 64) ? mem[s_araddr[5:2]] : 32'h0;
                        rresp  = (s_araddr < 64) ? 2'b00 : 2'b11;
                    end else r_cnt++;
                end
                if (rvalid && rready) begin r_fire = 1; n_r++; end
                if (awvalid === 1'b1 && !aw_got) begin
                    if (aw_cnt >= aw_lat) begin
                        awready = 1; aw_got = 1; s_awaddr = awaddr; n_aw++;
                    end else aw_cnt++;
                end
                if (wvalid === 1'b1 && !w_got) begin
                    if (w_cnt >= w_lat) begin
                        wready = 1; w_got = 1; s_wdata = wdata; s_wstrb = wstrb; n_w++;
                    end else w_cnt++;
                end
                if (arvalid === 1'b1 && !ar_got) begin
                    if (ar_cnt >= ar_lat) begin
                        arready = 1; ar_got = 1; s_araddr = araddr; n_ar++;
                    end else ar_cnt++;
                end
            end
        end
    end

    // ---------------- protocol monitor ----------------
    int prot_err = 0;
    int aw_hi = 0, w_hi = 0, ar_hi = 0, rr_hi = 0;
    logic p_awv = 0, p_awr = 0, p_wv = 0, p_wr = 0, p_arv = 0, p_arr = 0, p_rspv = 0, p_rspr = 0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;
    logic [3:0]  p_wstrb = '0;
    logic [34:0] p_rsp = '0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst_q) begin
                if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
                    prot_err++; $display("protocol: active output after reset edge at cycle %0d", cyc);
                end
            end else begin
                if (p_awv && !p_awr && (awvalid !== 1'b1 || awaddr !== p_awaddr)) begin
                    prot_err++; $display("protocol: AW unstable at cycle %0d", cyc);
                end
                if (p_wv && !p_wr && (wvalid !== 1'b1 || wdata !== p_wdata || wstrb !== p_wstrb)) begin
                    prot_err++; $display("protocol: W unstable at cycle %0d", cyc);
                end
                if (p_arv && !p_arr && (arvalid !== 1'b1 || araddr !== p_araddr)) begin
                    prot_err++; $display("protocol: AR unstable at cycle %0d", cyc);
                end
                if (p_rspv && !p_rspr && (rsp_valid !== 1'b1 || {rsp_rdata, rsp_resp, rsp_write} !== p_rsp)) begin
                    prot_err++; $display("protocol: rsp unstable at cycle %0d", cyc);
                end
            end
            if ((awvalid === 1'b1 || wvalid === 1'b1 || bready === 1'b1) &&
                (arvalid === 1'b1 || rready === 1'b1)) begin
                prot_err++; $display("protocol: read and write overlap at cycle %0d", cyc);
            end
            if (awvalid === 1'b1) aw_hi++;
            if (wvalid === 1'b1)  w_hi++;
            if (arvalid === 1'b1) ar_hi++;
            if (rready === 1'b1)  rr_hi++;
            p_awv = awvalid; p_awr = awready; p_awaddr = awaddr;
            p_wv = wvalid; p_wr = wready; p_wdata = wdata; p_wstrb = wstrb;
            p_arv = arvalid; p_arr = arready; p_araddr = araddr;
            p_rspv = rsp_valid; p_rspr = rsp_ready; p_rsp = {rsp_rdata, rsp_resp, rsp_write};
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic xact(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic ok, output int lat, output logic [31:0] rd,
                        output logic [1:0] rr, output logic rw);
        int t;
        int acc;
        ok = 1'b1;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) ok = 1'b0;
        acc = cyc;
        @(negedge clk);
        cmd_valid = 1'b0;
        t = 0;
        while (rsp_valid !== 1'b1 && t < 300) begin @(negedge clk); t++; end
        if (t >= 300) ok = 1'b0;
        lat = cyc - acc;
        rd = rsp_rdata; rr = rsp_resp; rw = rsp_write;
    endtask

    task automatic ack_rsp();
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        for (int j = 0; j < 4; j++)
            if (s[j]) ref_mem[a[5:2]][8*j +: 8] = d[8*j +: 8];
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++;
        if (cmd_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_cmd_ready_in_reset: got %b want 0", cmd_ready);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid} !== 6'b0) begin
            n_fail++; $display("FAIL reset_valids: got %b want 000000",
                               {awvalid, wvalid, bready, arvalid, rready, rsp_valid});
        end
        n_cmp++;
        if ({rsp_rdata, rsp_resp, rsp_write} !== 35'h0) begin
            n_fail++; $display("FAIL reset_rsp_fields: got %h want 0", {rsp_rdata, rsp_resp, rsp_write});
        end
        n_cmp++;
        if (cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_cmd_ready_after: got %b want 1", cmd_ready);
        end
    endtask

    task automatic test_write_basic();
        logic ok; int lat; logic [31:0] rd; logic [1:0] rr; logic rw;
        n_aw = 0; n_w = 0; n_b = 0;
        xact(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ok, lat, rd, rr, rw);
        ref_write(32'h10, 32'hDEADBEEF, 4'hF);
        n_cmp++;
        if (ok !== 1'b1 || lat != 3) begin
            n_fail++; $display("FAIL wr_latency: got ok=%b lat=%0d want ok=1 lat=3", ok, lat);
        end
        n_cmp++;
        if ({rd, rr, rw} !== {32'h0, 2'b00, 1'b1}) begin
            n_fail++; $display("FAIL wr_rsp: got rdata=%h resp=%b write=%b want 0/00/1", rd, rr, rw);
        end
        n_cmp++;
        if ({s_awaddr, s_wdata, s_wstrb} !== {32'h10, 32'hDEADBEEF, 4'hF}) begin
            n_fail++; $display("FAIL wr_payload: got %h/%h/%h want 10/deadbeef/f", s_awaddr, s_wdata, s_wstrb);
        end
        n_cmp++;
        if (n_aw != 1 || n_w != 1 || n_b != 1 || {awprot, arprot} !== 6'b0) begin
            n_fail++; $display("FAIL wr_beats: got aw=%0d w=%0d b=%0d prot=%b want 1/1/1/0",
                               n_aw, n_w, n_b, {awprot, arprot});
        end
        ack_rsp();
    endtask

    task automatic test_aw_stall();
        logic ok; int lat; logic [31:0] rd; logic [1:0] rr; logic rw;
        aw_lat = 5; n_b = 0; aw_hi = 0; w_hi = 0;
        xact(1'b1, 32'h20, 32'hCAFEF00D, 4'h3, ok, lat, rd, rr, rw);
        ref_write(32'h20, 32'hCAFEF00D, 4'h3);
        n_cmp++;
        if (ok !== 1'b1 || lat != 8 || rr !== 2'b00 || rw !== 1'b1) begin
            n_fail++; $display("FAIL aw_stall_rsp: got ok=%b lat=%0d resp=%b write=%b want 1/8/00/1", ok, lat, rr, rw);
        end
        n_cmp++;
        if (aw_hi != 6 || w_hi != 1 || n_b != 1) begin
            n_fail++; $display("FAIL aw_stall_cycles: got awvalid=%0d wvalid=%0d b=%0d want 6/1/1", aw_hi, w_hi, n_b);
        end
        ack_rsp();
        aw_lat = 0;
        xact(1'b0, 32'h20, 32'h0, 4'h0, ok, lat, rd, rr, rw);
        n_cmp++;
        if (ok !== 1'b1 || rd !== 32'h0000F00D || rr !== 2'b00 || rw !== 1'b0) begin
            n_fail++; $display("FAIL strb_readback: got ok=%b rdata=%h resp=%b write=%b want 1/0000f00d/00/0", ok, rd, rr, rw);
        end
        ack_rsp();
    endtask

    task automatic test_read_delay();
        logic ok; int lat; logic [31:0] rd; logic [1:0] rr; logic rw;
        mem[1] = 32'h12345678; ref_mem[1] = 32'h12345678;
        r_lat = 4; ar_hi = 0; rr_hi = 0;
        xact(1'b0, 32'h04, 32'h0, 4'h0, ok, lat, rd, rr, rw);
        n_cmp++;
        if (ok !== 1'b1 || lat != 7) begin
            n_fail++; $display("FAIL rd_latency: got ok=%b lat=%0d want 1/7", ok, lat);
        end
        n_cmp++;
        if ({rd, rr, rw} !== {32'h12345678, 2'b00, 1'b0}) begin
            n_fail++; $display("FAIL rd_rsp: got rdata=%h resp=%b write=%b want 12345678/00/0", rd, rr, rw);
        end
        n_cmp++;
        if (ar_hi != 1 || rr_hi != 5) begin
            n_fail++; $display("FAIL rd_cycles: got arvalid=%0d rready=%0d want 1/5", ar_hi, rr_hi);
        end
        ack_rsp();
        r_lat = 0;
    endtask

    task automatic test_rsp_stall();
        logic ok; int lat; logic [31:0] rd; logic [1:0] rr; logic rw;
        xact(1'b0, 32'h100, 32'h0, 4'h0, ok, lat, rd, rr, rw);
        n_cmp++;
        if (ok !== 1'b1 || rd !== 32'h0 || rr !== 2'b11 || rw !== 1'b0) begin
            n_fail++; $display("FAIL decerr_rsp: got ok=%b rdata=%h resp=%b write=%b want 1/0/11/0", ok, rd, rr, rw);
        end
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_cmp++;
            if ({rsp_valid, rsp_rdata, rsp_resp, rsp_write, cmd_ready} !== {1'b1, 32'h0, 2'b11, 1'b0, 1'b0}) begin
                n_fail++; $display("FAIL rsp_hold_%0d: got valid=%b rdata=%h resp=%b cmd_ready=%b want 1/0/11/0",
                                   k, rsp_valid, rsp_rdata, rsp_resp, cmd_ready);
            end
        end
        ack_rsp();
        n_cmp++;
        if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            n_fail++; $display("FAIL rsp_release: got rsp_valid=%b cmd_ready=%b want 0/1", rsp_valid, cmd_ready);
        end
    endtask

    task automatic test_reset_mid();
        int seen;
        int t;
        aw_lat = 1000;
        @(negedge clk);
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h30; cmd_wdata = 32'h55AA55AA; cmd_wstrb = 4'hF;
        t = 0;
        while (cmd_ready !== 1'b1 && t < 100) begin @(negedge clk); t++; end
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (awvalid !== 1'b1) begin
            n_fail++; $display("FAIL mid_awvalid_pending: got %b want 1", awvalid);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready} !== 7'b0000001) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %b want 0000001",
                               {awvalid, wvalid, bready, arvalid, rready, rsp_valid, cmd_ready});
        end
        seen = 0;
        repeat (10) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen != 0) begin
            n_fail++; $display("FAIL mid_reset_no_rsp: got %0d rsp_valid cycles want 0", seen);
        end
        aw_lat = 0;
    endtask

    task automatic test_back_to_back();
        logic ok; int lat; logic [31:0] rd; logic [1:0] rr; logic rw;
        logic w; logic [31:0] a; logic [31:0] d; logic [3:0] s; logic [31:0] exp_rd;
        for (int i = 0; i < 100; i++) begin
            w = 1'($urandom_range(0, 1));
            a = 32'($urandom_range(0, 15)) << 2;
            d = $urandom;
            s = 4'($urandom_range(1, 15));
            aw_lat = $urandom_range(0, 3); w_lat = $urandom_range(0, 3); b_lat = $urandom_range(0, 3);
            ar_lat = $urandom_range(0, 3); r_lat = $urandom_range(0, 3);
            exp_rd = w ? 32'h0 : ref_mem[a[5:2]];
            xact(w, a, d, s, ok, lat, rd, rr, rw);
            if (w) ref_write(a, d, s);
            n_cmp++;
            if (ok !== 1'b1 || {rd, rr, rw} !== {exp_rd, 2'b00, w}) begin
                n_fail++; $display("FAIL b2b_%0d: got ok=%b rdata=%h resp=%b write=%b want rdata=%h resp=00 write=%b",
                                   i, ok, rd, rr, rw, exp_rd, w);
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
            ack_rsp();
        end
        n_cmp++;
        if (prot_err != 0) begin
            n_fail++; $display("FAIL protocol_clean: got %0d violations want 0", prot_err);
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'h0;
            ref_mem[i] = 32'h0;
        end
        test_reset();
        test_write_basic();
        test_aw_stall();
        test_read_delay();
        test_rsp_stall();
        test_reset_mid();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
